// File: rtl/mips_run_controller.sv
// Run/step/halt sequencer for the 16-bit single-cycle MIPS core: gates the datapath with cpu_en,
// adds a PC breakpoint, a saturating retired-instruction counter and halt-reason reporting.
// Optional same-PC watchdog enabled by defining MIPS_RUN_CTRL_WDOG_EN.
module mips_run_controller #(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              cmd_clear,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [1:0]        halt_reason,
  output logic [CNT_W-1:0]  instr_count,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_STEP   = 2'b10;
  localparam logic [1:0] ST_HALTED = 2'b11;

  localparam logic [1:0] RSN_NONE = 2'd0;
  localparam logic [1:0] RSN_CMD  = 2'd1;
  localparam logic [1:0] RSN_BP   = 2'd2;
  localparam logic [1:0] RSN_WDOG = 2'd3;

  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("mips_run_controller: WDOG_CYCLES must be at least 1");
  end

  logic       bp_skip;
  logic       bp_hit;
  logic       wdog_hit;
  logic [1:0] state_nxt;
  logic [1:0] reason_nxt;
  logic       skip_set;

  assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip;
  assign busy   = (state == ST_RUN) | (state == ST_STEP);
  assign cpu_en = (state == ST_STEP) |
                  ((state == ST_RUN) & ~cmd_halt & ~bp_hit & ~wdog_hit);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    reason_nxt = halt_reason;
    skip_set   = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALTED: begin
        if (cmd_halt) begin
          state_nxt  = ST_HALTED;
          reason_nxt = RSN_CMD;
        end else if (cmd_step || cmd_run) begin
          state_nxt  = cmd_step ? ST_STEP : ST_RUN;
          reason_nxt = RSN_NONE;
          // Resuming from a breakpoint must let the instruction at bp_addr commit once.
          skip_set   = (state == ST_HALTED) && (halt_reason == RSN_BP);
        end
      end
      ST_RUN: begin
        if (cmd_halt) begin
          state_nxt  = ST_HALTED;
          reason_nxt = RSN_CMD;
        end else if (bp_hit) begin
          state_nxt  = ST_HALTED;
          reason_nxt = RSN_BP;
        end else if (wdog_hit) begin
          state_nxt  = ST_HALTED;
          reason_nxt = RSN_WDOG;
        end
      end
      default: begin
        state_nxt  = ST_HALTED;
        reason_nxt = RSN_CMD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      halt_reason <= RSN_NONE;
      bp_skip     <= 1'b0;
    end else begin
      state       <= state_nxt;
      halt_reason <= reason_nxt;
      if (skip_set)    bp_skip <= 1'b1;
      else if (cpu_en) bp_skip <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          instr_count <= '0;
    else if (cmd_clear)                  instr_count <= '0;
    else if (cpu_en && !(&instr_count))  instr_count <= instr_count + 1'b1;
  end

`ifdef MIPS_RUN_CTRL_WDOG_EN
  localparam int SAME_W = $clog2(WDOG_CYCLES + 1);

  logic [ADDR_W-1:0] last_pc;
  logic              last_valid;
  logic [SAME_W-1:0] same_cnt;
  logic              leaving;
  logic              entering_run;

  assign wdog_hit     = (same_cnt == SAME_W'(WDOG_CYCLES));
  assign leaving      = busy && (state_nxt != ST_RUN) && (state_nxt != ST_STEP);
  assign entering_run = (state != ST_RUN) && (state_nxt == ST_RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_pc    <= '0;
      last_valid <= 1'b0;
      same_cnt   <= '0;
    end else begin
      if (cpu_en) last_pc <= pc;
      if (leaving)     last_valid <= 1'b0;
      else if (cpu_en) last_valid <= 1'b1;
      if (entering_run) same_cnt <= '0;
      else if (cpu_en)  same_cnt <= (last_valid && pc == last_pc) ? same_cnt + 1'b1 : '0;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed self-checking bench for mips_run_controller (CNT_W=4, WDOG_CYCLES=3);
// watchdog expectations follow whether MIPS_RUN_CTRL_WDOG_EN is defined.
module tb_mips_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_run, cmd_step, cmd_halt, cmd_clear, bp_en;
  logic [15:0] bp_addr, pc;
  logic        cpu_en, busy;
  logic [1:0]  state, halt_reason;
  logic [3:0]  instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  mips_run_controller #(.ADDR_W(16), .CNT_W(4), .WDOG_CYCLES(3)) dut (
    .clock(clock), .reset(reset),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_clear(cmd_clear),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .state(state), .halt_reason(halt_reason),
    .instr_count(instr_count), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; cmd_run = 0; cmd_step = 0; cmd_halt = 0; cmd_clear = 0;
    bp_en = 0; bp_addr = 16'h0; pc = 16'h0;
    #2;
    check("rst_state", state, 2'b00);
    check("rst_cpu_en", cpu_en, 1'b0);
    check("rst_reason", halt_reason, 2'd0);
    check("rst_count", instr_count, 4'd0);
    check("rst_busy", busy, 1'b0);
    #10 reset = 1'b1;

    // Single step at pc=4
    cmd_step = 1; pc = 16'h0004; #1;
    check("idle_no_en", cpu_en, 1'b0);
    cyc(); cmd_step = 0; #1;
    check("step_state", state, 2'b10);
    check("step_busy", busy, 1'b1);
    check("step_en", cpu_en, 1'b1);
    cyc();
    check("step_done_state", state, 2'b11);
    check("step_done_reason", halt_reason, 2'd1);
    check("step_done_count", instr_count, 4'd1);
    check("step_done_en", cpu_en, 1'b0);

    // Breakpoint at 0x10
    bp_en = 1; bp_addr = 16'h0010; pc = 16'h0000; cmd_run = 1;
    cyc(); cmd_run = 0;
    check("run_state", state, 2'b01);
    check("run_reason_cleared", halt_reason, 2'd0);
    for (int i = 0; i < 4; i++) begin
      pc = 16'(i * 4); #1;
      check("bp_run_en", cpu_en, 1'b1);
      cyc();
    end
    check("bp_pre_count", instr_count, 4'd5);
    pc = 16'h0010; #1;
    check("bp_hit_en", cpu_en, 1'b0);
    cyc();
    check("bp_state", state, 2'b11);
    check("bp_reason", halt_reason, 2'd2);
    check("bp_count", instr_count, 4'd5);

    // Resume: instruction at the breakpoint commits once
    cmd_run = 1; cyc(); cmd_run = 0; #1;
    check("resume_state", state, 2'b01);
    check("resume_skip_en", cpu_en, 1'b1);
    cyc();
    check("resume_count", instr_count, 4'd6);
    pc = 16'h0014; #1;
    check("resume_next_en", cpu_en, 1'b1);
    cyc();
    check("resume_still_run", state, 2'b01);
    check("resume_count2", instr_count, 4'd7);

    // Halt and clear together
    cmd_halt = 1; cmd_clear = 1; #1;
    check("halt_clear_en", cpu_en, 1'b0);
    cyc(); cmd_halt = 0; cmd_clear = 0;
    check("halt_state", state, 2'b11);
    check("halt_reason", halt_reason, 2'd1);
    check("clear_count", instr_count, 4'd0);

    // Saturation with a 4-bit counter
    bp_en = 0; cmd_run = 1; cyc(); cmd_run = 0;
    for (int i = 0; i < 20; i++) begin
      pc = 16'h0100 + 16'(i * 4);
      cyc();
      if (i == 14) check("sat_reach_f", instr_count, 4'hF);
    end
    check("sat_hold_f", instr_count, 4'hF);
    check("sat_still_run", state, 2'b01);

    // Asynchronous reset between edges while running
    #2 reset = 1'b0; #1;
    check("arst_state", state, 2'b00);
    check("arst_en", cpu_en, 1'b0);
    check("arst_count", instr_count, 4'd0);
    check("arst_busy", busy, 1'b0);
    #1 reset = 1'b1;
    cyc();

    // Simultaneous run+step in IDLE picks STEP; halt during STEP does not cancel it
    cmd_run = 1; cmd_step = 1; cyc(); cmd_run = 0; cmd_step = 0;
    check("run_step_state", state, 2'b10);
    cyc();
    check("run_step_count", instr_count, 4'd1);
    cmd_step = 1; cyc(); cmd_step = 0; cmd_halt = 1; #1;
    check("step_halt_en", cpu_en, 1'b1);
    cyc(); cmd_halt = 0;
    check("step_halt_state", state, 2'b11);
    check("step_halt_reason", halt_reason, 2'd1);
    check("step_halt_count", instr_count, 4'd2);

    // Breakpoint ignored while stepping
    bp_en = 1; bp_addr = 16'h0040; pc = 16'h0040; cmd_step = 1;
    cyc(); cmd_step = 0; #1;
    check("step_bp_en", cpu_en, 1'b1);
    cyc();
    check("step_bp_reason", halt_reason, 2'd1);
    check("step_bp_count", instr_count, 4'd3);
    bp_en = 0;

    // Spin loop at pc=0x20
    pc = 16'h0020; cmd_run = 1; cyc(); cmd_run = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("spin_en", cpu_en, 1'b1);
      cyc();
    end
`ifdef MIPS_RUN_CTRL_WDOG_EN
    check("wdog_en_drop", cpu_en, 1'b0);
    cyc();
    check("wdog_state", state, 2'b11);
    check("wdog_reason", halt_reason, 2'd3);
    check("wdog_count", instr_count, 4'd7);
`else
    for (int i = 0; i < 6; i++) begin
      #1 check("no_wdog_en", cpu_en, 1'b1);
      cyc();
    end
    check("no_wdog_state", state, 2'b01);
    check("no_wdog_reason", halt_reason, 2'd0);
    check("no_wdog_count", instr_count, 4'd13);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Run/step/halt sequencer for the 16-bit single-cycle MIPS core.
- Drives a clock-enable (cpu_en) into the datapath, so the core commits at most one instruction per clock edge.
- Adds PC breakpoint, retired-instruction counter and halt-reason reporting.
- Sits between the board/debug command inputs and the CPU top level; the CPU register/PC/memory writes are qualified by cpu_en.

Parameters:
ADDR_W, 16, width of pc and bp_addr
CNT_W, 32, width of instr_count (saturating)
WDOG_CYCLES, 16, consecutive same-PC commits before watchdog halt (used only with the optional feature)

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cmd_run  input  1  one-cycle pulse: enter RUN
cmd_step  input  1  one-cycle pulse: execute exactly one instruction
cmd_halt  input  1  one-cycle pulse: stop execution
cmd_clear  input  1  pulse: zero instr_count
bp_en  input  1  breakpoint enable
bp_addr  input  ADDR_W  breakpoint PC
pc  input  ADDR_W  PC of the instruction the core will commit on the next enabled edge
cpu_en  output  1  datapath clock enable; combinational from state and inputs
state  output  2  IDLE=00, RUN=01, STEP=10, HALTED=11
halt_reason  output  2  0 none, 1 command/step done, 2 breakpoint, 3 watchdog
instr_count  output  CNT_W  instructions committed (cycles with cpu_en=1)
busy  output  1  1 when state is RUN or STEP

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, cpu_en=0, halt_reason=0, instr_count=0, busy=0.
  - Internal bp_skip=0 and watchdog counter=0.
- bp_hit = bp_en & (pc==bp_addr) & !bp_skip.
- cpu_en = (state==STEP) | (state==RUN & !cmd_halt & !bp_hit & !wdog_hit). There is no latency; the command takes effect in the same cycle it is sampled.
- Command priority, sampled every cycle: halt > step > run.
- IDLE / HALTED:
  - cmd_halt -> HALTED, reason=1.
  - Else cmd_step -> STEP.
  - Else cmd_run -> RUN.
  - On entering RUN/STEP from HALTED with reason=2, set bp_skip=1, so the instruction at the breakpoint executes once.
- RUN:
  - cmd_halt -> HALTED, reason=1, cpu_en=0 this cycle.
  - Else bp_hit -> HALTED, reason=2, cpu_en=0.
  - Else wdog_hit -> HALTED, reason=3, cpu_en=0.
  - cmd_run and cmd_step are ignored in RUN.
- STEP:
  - cpu_en=1 for exactly one cycle (breakpoint ignored), then HALTED with reason=1.
  - cmd_halt in STEP does not cancel the step; the step still commits and reason=1.
- bp_skip clears on the first clock edge with cpu_en=1.
- halt_reason holds its value until the next transition into HALTED. It resets to 0 on entering RUN or STEP.
- instr_count:
  - +1 on each edge with cpu_en=1; saturates at all-ones (no wrap).
  - cmd_clear forces 0 and wins over a simultaneous increment.
  - Clear is accepted in any state.
- Reset asserted mid-RUN aborts immediately: cpu_en drops to 0 asynchronously with the state change to IDLE.
- Simultaneous cmd_run and cmd_step in IDLE -> STEP.

Optional Feature:
- Macro MIPS_RUN_CTRL_WDOG_EN.
- Defined:
  - Register last_pc, captured on each cpu_en edge, with a valid flag cleared on leaving RUN/STEP.
  - same_cnt increments on a cpu_en edge where pc==last_pc and valid; otherwise it is set to 0 on cpu_en. It is cleared on any entry into RUN.
  - wdog_hit = (same_cnt==WDOG_CYCLES). This catches "j self" spin loops.
- Undefined: wdog_hit is constant 0, no watchdog registers exist, and halt_reason never equals 3.

Test Plan:
- Reset then cmd_step with pc=0x0004 -> cpu_en=1 for 1 cycle, then state=11, halt_reason=1, instr_count=1.
- Breakpoint:
  - bp_en=1, bp_addr=0x0010, cmd_run, pc advancing 0,4,8,0xC,0x10 -> 4 commits, cpu_en=0 at pc=0x10, state=11, reason=2.
  - Then cmd_run -> the instruction at 0x10 commits once and RUN continues.
- RUN for 5 commits, then cmd_halt and cmd_clear in the same cycle -> cpu_en=0 that cycle, state=11, reason=1, instr_count=0.
- Saturation: with CNT_W=4, run 20 cycles -> instr_count stays 0xF.
- reset driven 0 mid-RUN, asynchronously between clock edges -> state=00, cpu_en=0, instr_count=0 before the next edge.
- With MIPS_RUN_CTRL_WDOG_EN and WDOG_CYCLES=3, pc held at 0x0020 in RUN -> cpu_en=0 once same_cnt=3, reason=3. Without the macro, the same stimulus keeps RUN indefinitely.
